// File: rtl/coeff_mem_loader.sv
// Coefficient memory loader: streams DATA_DEPTH words into memory, reads them
// back, and compares write and read-back sums to report a checksum and error flag.
module coeff_mem_loader #(
    parameter int DATA_WIDTH = 19,
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_DEPTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [24:0]           checksum
);

    localparam int SUM_WIDTH = 25;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        VERIFY,
        CHECK
    } state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] waddr, raddr;
    logic [SUM_WIDTH-1:0]  wsum, rsum, rsum_next;
    logic                  rd_pending;
    logic                  accept;

    assign accept = (state == LOAD) && s_valid;

    // Read data trails its address by one cycle, so the sum lags the address.
    assign rsum_next = rsum + (rd_pending ? SUM_WIDTH'(mem_rdata) : SUM_WIDTH'(0));

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
        state_next = state;
        s_ready    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = LOAD;
            end
            LOAD: begin
                s_ready   = 1'b1;
                mem_we    = s_valid;
                mem_addr  = waddr;
                mem_wdata = s_data;
                if (s_valid && waddr == LAST_ADDR) state_next = VERIFY;
            end
            VERIFY: begin
                mem_addr = raddr;
                if (raddr == LAST_ADDR) state_next = CHECK;
            end
            CHECK: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            waddr      <= '0;
            raddr      <= '0;
            wsum       <= '0;
            rsum       <= '0;
            rd_pending <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            checksum   <= '0;
        end else begin
            state      <= state_next;
            rd_pending <= (state == VERIFY);
            case (state)
                IDLE: begin
                    if (start) begin
                        waddr <= '0;
                        raddr <= '0;
                        wsum  <= '0;
                        rsum  <= '0;
                        done  <= 1'b0;
                        err   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        waddr <= waddr + 1'b1;
                        wsum  <= wsum + SUM_WIDTH'(s_data);
                    end
                end
                VERIFY: begin
                    raddr <= raddr + 1'b1;
                    rsum  <= rsum_next;
                end
                CHECK: begin
                    // The final read word lands this cycle, so compare against rsum_next.
                    rsum     <= rsum_next;
                    done     <= 1'b1;
                    err      <= (wsum != rsum_next);
                    checksum <= wsum;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_coeff_mem_loader.sv
// Directed bench for coeff_mem_loader with a one-cycle-latency memory model.
module tb_coeff_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [18:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [18:0] mem_wdata;
    logic [18:0] mem_rdata = '0;
    logic        busy;
    logic        done;
    logic        err;
    logic [24:0] checksum;

    int tests_run = 0;
    int tests_failed = 0;

    logic [18:0] model_mem [64];
    bit          corrupt = 1'b0;
    int          write_count = 0;
    int          bad_we = 0;
    int          order_err = 0;
    int          exp_waddr = 0;

    coeff_mem_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    // Memory model plus write monitor; the corrupt flag perturbs read-back at address 10.
    always @(posedge clk) begin
        if (mem_we) begin
            model_mem[mem_addr] <= mem_wdata;
            write_count = write_count + 1;
            if (!s_valid) bad_we = bad_we + 1;
            if (int'(mem_addr) != exp_waddr) order_err = order_err + 1;
            exp_waddr = exp_waddr + 1;
        end
        mem_rdata <= model_mem[mem_addr] + ((corrupt && mem_addr == 6'd10) ? 19'd1 : 19'd0);
    end

    task automatic clear_monitor();
        @(negedge clk);
        write_count = 0;
        bad_we      = 0;
        order_err   = 0;
        exp_waddr   = 0;
    endtask

    // Starts a pass and feeds up to 64 words; records the cycle in which done is first seen.
    task automatic run_pass(input bit gaps, input bit sat, input bit extra_start,
                            input int feed_limit, output int done_cycle);
        int  cyc;
        int  idx;
        bit  acc;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        cyc = 0;
        idx = 0;
        done_cycle = -1;
        while (cyc < 400 && done_cycle < 0 && !(feed_limit < 64 && idx >= feed_limit)) begin
            @(negedge clk);
            start = extra_start && (cyc == 5);
            if (idx < feed_limit && (!gaps || cyc % 2 == 0)) begin
                s_valid = 1'b1;
                s_data  = sat ? 19'h7FFFF : 19'(idx);
            end else begin
                s_valid = 1'b0;
                s_data  = '0;
            end
            #1 acc = s_valid && s_ready;
            @(posedge clk);
            cyc++;
            if (acc) idx++;
            #1;
            if (done && done_cycle < 0) done_cycle = cyc + 1;
        end
        @(negedge clk);
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
    endtask

    task automatic test_reset();
        int dc;
        #3 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({s_ready, mem_we, mem_addr, mem_wdata, busy, done, err, checksum} !== '0) begin
            tests_failed++;
            $display("FAIL reset_initial: outputs=%h required 0",
                     {s_ready, mem_we, mem_addr, mem_wdata, busy, done, err, checksum});
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_monitor();
        run_pass(1'b0, 1'b0, 1'b0, 3, dc);
        s_valid = 1'b1;
        s_data  = 19'h1234;
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({s_ready, mem_we, mem_addr, mem_wdata, busy, done, err, checksum} !== '0) begin
            tests_failed++;
            $display("FAIL reset_midcycle: outputs=%h required 0",
                     {s_ready, mem_we, mem_addr, mem_wdata, busy, done, err, checksum});
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = '0;
        rst_n   = 1'b1;
    endtask

    task automatic test_ramp();
        int dc;
        corrupt = 1'b0;
        clear_monitor();
        run_pass(1'b0, 1'b0, 1'b0, 64, dc);
        tests_run++;
        if (dc != 130) begin
            tests_failed++;
            $display("FAIL ramp_latency: done cycle=%0d required 130", dc);
        end
        tests_run++;
        if (write_count != 64 || order_err != 0) begin
            tests_failed++;
            $display("FAIL ramp_writes: count=%0d order_err=%0d required 64/0", write_count, order_err);
        end
        tests_run++;
        if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL ramp_flags: done=%b err=%b busy=%b required 1/0/0", done, err, busy);
        end
        tests_run++;
        if (checksum !== 25'd2016) begin
            tests_failed++;
            $display("FAIL ramp_checksum: got %0d required 2016", checksum);
        end
    endtask

    task automatic test_gaps();
        int dc;
        clear_monitor();
        run_pass(1'b1, 1'b0, 1'b0, 64, dc);
        tests_run++;
        if (bad_we != 0 || write_count != 64 || order_err != 0) begin
            tests_failed++;
            $display("FAIL gaps_writes: gap_we=%0d count=%0d order_err=%0d required 0/64/0",
                     bad_we, write_count, order_err);
        end
        tests_run++;
        if (done !== 1'b1 || err !== 1'b0 || checksum !== 25'd2016) begin
            tests_failed++;
            $display("FAIL gaps_result: done=%b err=%b checksum=%0d required 1/0/2016", done, err, checksum);
        end
    endtask

    task automatic test_corrupt();
        int dc;
        corrupt = 1'b1;
        clear_monitor();
        run_pass(1'b0, 1'b0, 1'b0, 64, dc);
        corrupt = 1'b0;
        tests_run++;
        if (done !== 1'b1 || err !== 1'b1) begin
            tests_failed++;
            $display("FAIL corrupt_err: done=%b err=%b required 1/1", done, err);
        end
        tests_run++;
        if (checksum !== 25'd2016) begin
            tests_failed++;
            $display("FAIL corrupt_checksum: got %0d required 2016", checksum);
        end
    endtask

    task automatic test_saturate_start();
        int dc;
        clear_monitor();
        run_pass(1'b0, 1'b1, 1'b1, 64, dc);
        tests_run++;
        if (checksum !== 25'd33554368 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL sat_checksum: got %0d err=%b required 33554368/0", checksum, err);
        end
        tests_run++;
        if (dc != 130) begin
            tests_failed++;
            $display("FAIL sat_latency: done cycle=%0d required 130", dc);
        end
        repeat (10) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || write_count != 64) begin
            tests_failed++;
            $display("FAIL sat_single_pass: busy=%b count=%0d required 0/64", busy, write_count);
        end
    endtask

    task automatic test_reset_mid_load();
        int dc;
        clear_monitor();
        run_pass(1'b0, 1'b0, 1'b0, 20, dc);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || write_count != 20) begin
            tests_failed++;
            $display("FAIL midload_abort: busy=%b done=%b count=%0d required 0/0/20", busy, done, write_count);
        end
        clear_monitor();
        run_pass(1'b0, 1'b0, 1'b0, 64, dc);
        tests_run++;
        if (write_count != 64 || order_err != 0) begin
            tests_failed++;
            $display("FAIL midload_restart: count=%0d order_err=%0d required 64/0", write_count, order_err);
        end
        tests_run++;
        if (done !== 1'b1 || err !== 1'b0 || checksum !== 25'd2016) begin
            tests_failed++;
            $display("FAIL midload_result: done=%b err=%b checksum=%0d required 1/0/2016", done, err, checksum);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_gaps();
        test_corrupt();
        test_saturate_start();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
